// File: rtl/oai222_sweep_pkg.sv
// Shared types, widths and the golden OAI222 function for the sweep checker.
package oai222_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FIN
  } state_e;

  localparam int VEC_W = 6;
  localparam int CNT_W = 7;
  localparam logic [CNT_W-1:0] FAIL_SAT = 7'd127;

  // vec = {C2,C1,B2,B1,A2,A1}
  function automatic logic oai222_golden(input logic [VEC_W-1:0] vec);
    return !((vec[0] | vec[1]) & (vec[2] | vec[3]) & (vec[4] | vec[5]));
  endfunction

endpackage

// File: rtl/oai222_sweep_seq.sv
// Vector, loop and settle counters for the sweep, with terminal-count flags.
module oai222_sweep_seq
  import oai222_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             tick_i,
  input  logic             advance_i,
  input  logic             park_i,
  output logic [VEC_W-1:0] vec_o,
  output logic             settle_done_o,
  output logic             last_o
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [7:0] LOOP_LAST   = 8'(LOOPS - 1);

  logic [VEC_W-1:0] vec_q, vec_d;
  logic [7:0]       loop_q, loop_d;
  logic [3:0]       settle_q, settle_d;

  // NOTE: every next-state signal gets a hold default first so no latch is inferred.
  always_comb begin
    vec_d    = vec_q;
    loop_d   = loop_q;
    settle_d = settle_q;
    if (start_i) begin
      vec_d    = '0;
      loop_d   = '0;
      settle_d = SETTLE_LOAD;
    end else if (park_i) begin
      vec_d  = '0;
      loop_d = '0;
    end else if (advance_i) begin
      vec_d    = vec_q + 1'b1;
      settle_d = SETTLE_LOAD;
      if (vec_q == '1) loop_d = loop_q + 8'd1;
    end else if (tick_i) begin
      settle_d = settle_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q    <= '0;
      loop_q   <= '0;
      settle_q <= '0;
    end else begin
      vec_q    <= vec_d;
      loop_q   <= loop_d;
      settle_q <= settle_d;
    end
  end

  assign vec_o         = vec_q;
  assign settle_done_o = (settle_q == 4'd1);
  assign last_o        = (vec_q == '1) && (loop_q == LOOP_LAST);

endmodule

// File: rtl/oai222_sweep_checker.sv
// Drives all 64 OAI222 input vectors, samples ZN after a settle time and
// accumulates mismatch statistics.
module oai222_sweep_checker
  import oai222_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOPS         = 1
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  output logic             A1,
  output logic             A2,
  output logic             B1,
  output logic             B2,
  output logic             C1,
  output logic             C2,
  input  logic             ZN_OBS,
  output logic             BUSY,
  output logic             DONE,
  output logic             FAIL,
  output logic [CNT_W-1:0] FAIL_CNT,
  output logic [VEC_W-1:0] FIRST_FAIL_VEC,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam state_e AFTER_LOAD = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

  state_e           state_q;
  logic             busy_q, done_q, fail_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [VEC_W-1:0] first_fail_q;

  logic [VEC_W-1:0] vec;
  logic             settle_done, last_vec;
  logic             start_go, tick, advance, park, mismatch;

  always_comb begin
    start_go = (state_q == ST_IDLE) && START;
    tick     = (state_q == ST_SETTLE) && !settle_done;
    advance  = (state_q == ST_SAMPLE) && !last_vec;
    park     = (state_q == ST_SAMPLE) && last_vec;
    // Case inequality so an X or Z on the observed pin counts as a miss.
    mismatch = (ZN_OBS !== oai222_golden(vec));
  end

  oai222_sweep_seq #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .LOOPS        (LOOPS)
  ) u_seq (
    .clk          (CLK),
    .rst_n        (RN),
    .start_i      (start_go),
    .tick_i       (tick),
    .advance_i    (advance),
    .park_i       (park),
    .vec_o        (vec),
    .settle_done_o(settle_done),
    .last_o       (last_vec)
  );

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_cnt_q   <= '0;
      first_fail_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (START) begin
            fail_q       <= 1'b0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            busy_q       <= 1'b1;
            state_q      <= AFTER_LOAD;
          end
        end
        ST_SETTLE: begin
          if (settle_done) state_q <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            fail_q <= 1'b1;
            if (fail_cnt_q != FAIL_SAT) fail_cnt_q <= fail_cnt_q + 1'b1;
            if (fail_cnt_q == '0) first_fail_q <= vec;
          end
          if (last_vec) begin
            busy_q  <= 1'b0;
            state_q <= ST_FIN;
          end else begin
            state_q <= AFTER_LOAD;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign {C2, C1, B2, B1, A2, A1} = vec;
  assign BUSY           = busy_q;
  assign DONE           = done_q;
  assign FAIL           = fail_q;
  assign FAIL_CNT       = fail_cnt_q;
  assign FIRST_FAIL_VEC = first_fail_q;

  // Supply pins carry no logic; fold them into a sink net.
  logic unused_rails;
  assign unused_rails = VDD ^ VSS;

endmodule

// File: tb/tb_oai222_sweep_checker.sv
// Bench for oai222_sweep_checker: three parameterisations, directed and random ZN faults.
module tb_oai222_sweep_checker;

  logic CLK = 1'b0;
  logic RN;
  logic start;
  int   sel;
  int   mode;
  logic [63:0] mask;
  int   tests = 0;
  int   fails = 0;

  wire vdd, vss;
  assign vdd = 1'b1;
  assign vss = 1'b0;

  always #5 CLK = ~CLK;

  // Reference cell: ZN is 0 only when every input pair has at least one bit set.
  function automatic logic golden_tb(input int v);
    return ((v % 4) != 0 && ((v / 4) % 4) != 0 && ((v / 16) % 4) != 0) ? 1'b0 : 1'b1;
  endfunction

  // mode 0: real cell, 1: stuck at 1, 2: stuck at 0, 3: cell with random flips
  function automatic logic zn_model(input int md, input logic [63:0] msk, input int v);
    case (md)
      1:       return 1'b1;
      2:       return 1'b0;
      3:       return golden_tb(v) ^ msk[v];
      default: return golden_tb(v);
    endcase
  endfunction

  logic [5:0] stim_d, stim_l, stim_z;
  logic       busy_d, busy_l, busy_z, done_d, done_l, done_z, fl_d, fl_l, fl_z;
  logic [6:0] cnt_d, cnt_l, cnt_z;
  logic [5:0] ffv_d, ffv_l, ffv_z;
  logic       zn_d, zn_l, zn_z;

  assign zn_d = zn_model(mode, mask, int'(stim_d));
  assign zn_l = zn_model(mode, mask, int'(stim_l));
  assign zn_z = zn_model(mode, mask, int'(stim_z));

  oai222_sweep_checker u_def (
    .CLK(CLK), .RN(RN), .START(start && sel == 0),
    .A1(stim_d[0]), .A2(stim_d[1]), .B1(stim_d[2]), .B2(stim_d[3]), .C1(stim_d[4]), .C2(stim_d[5]),
    .ZN_OBS(zn_d), .BUSY(busy_d), .DONE(done_d), .FAIL(fl_d), .FAIL_CNT(cnt_d),
    .FIRST_FAIL_VEC(ffv_d), .VDD(vdd), .VSS(vss)
  );

  oai222_sweep_checker #(.SETTLE_CYCLES(2), .LOOPS(4)) u_l4 (
    .CLK(CLK), .RN(RN), .START(start && sel == 1),
    .A1(stim_l[0]), .A2(stim_l[1]), .B1(stim_l[2]), .B2(stim_l[3]), .C1(stim_l[4]), .C2(stim_l[5]),
    .ZN_OBS(zn_l), .BUSY(busy_l), .DONE(done_l), .FAIL(fl_l), .FAIL_CNT(cnt_l),
    .FIRST_FAIL_VEC(ffv_l), .VDD(vdd), .VSS(vss)
  );

  oai222_sweep_checker #(.SETTLE_CYCLES(0), .LOOPS(1)) u_s0 (
    .CLK(CLK), .RN(RN), .START(start && sel == 2),
    .A1(stim_z[0]), .A2(stim_z[1]), .B1(stim_z[2]), .B2(stim_z[3]), .C1(stim_z[4]), .C2(stim_z[5]),
    .ZN_OBS(zn_z), .BUSY(busy_z), .DONE(done_z), .FAIL(fl_z), .FAIL_CNT(cnt_z),
    .FIRST_FAIL_VEC(ffv_z), .VDD(vdd), .VSS(vss)
  );

  logic [5:0] stim_s, ffv_s;
  logic [6:0] cnt_s;
  logic       busy_s, done_s, fl_s;

  always_comb begin
    stim_s = stim_d; busy_s = busy_d; done_s = done_d; fl_s = fl_d; cnt_s = cnt_d; ffv_s = ffv_d;
    if (sel == 1) begin
      stim_s = stim_l; busy_s = busy_l; done_s = done_l; fl_s = fl_l; cnt_s = cnt_l; ffv_s = ffv_l;
    end else if (sel == 2) begin
      stim_s = stim_z; busy_s = busy_z; done_s = done_z; fl_s = fl_z; cnt_s = cnt_z; ffv_s = ffv_z;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected result statistics of a full run, from counting over the sweep.
  task automatic expect_stats(input int loops, output int cnt, output int first);
    int raw = 0;
    first = 0;
    for (int l = 0; l < loops; l++)
      for (int v = 0; v < 64; v++)
        if (zn_model(mode, mask, v) != golden_tb(v)) begin
          if (raw == 0) first = v;
          raw++;
        end
    cnt = (raw > 127) ? 127 : raw;
  endtask

  task automatic check_results(input string tag, input int loops);
    int ecnt, efirst;
    expect_stats(loops, ecnt, efirst);
    check({tag, "_fail"}, fl_s, (ecnt != 0) ? 1 : 0);
    check({tag, "_cnt"}, cnt_s, ecnt);
    check({tag, "_first"}, ffv_s, efirst);
  endtask

  // Start one sweep on the selected instance; lat = edges from START to the DONE cycle.
  task automatic run_sweep(input int settle, input int loops, input int restart_at, output int lat);
    int n = loops * 64 * (settle + 1);
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    lat = 0;
    while (!done_s && lat < n + 20) begin
      if (lat < n) begin
        check("stim", stim_s, (lat / (settle + 1)) % 64);
        check("busy_run", busy_s, 1);
      end else if (lat == n) begin
        check("busy_fin", busy_s, 0);
        check("stim_fin", stim_s, 0);
      end
      start = (lat == restart_at);
      @(negedge CLK);
      lat++;
    end
    start = 1'b0;
    check("done_seen", done_s, 1);
    check("latency", lat, n + 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("done_single", done_s, 0);
      check("busy_idle", busy_s, 0);
      check("stim_idle", stim_s, 0);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int k;
    RN = 1'b0; start = 1'b0; sel = 0; mode = 0; mask = '0;
    repeat (3) @(negedge CLK);
    check("rst_stim", stim_d, 0);
    check("rst_busy", busy_d, 0);
    check("rst_done", done_d, 0);
    check("rst_fail", fl_d, 0);
    check("rst_cnt", cnt_d, 0);
    check("rst_ffv", ffv_d, 0);
    RN = 1'b1;
    @(negedge CLK);

    mode = 0;
    run_sweep(2, 1, -1, lat);
    check("good_lat", lat, 193);
    check_results("good", 1);

    mode = 1;
    run_sweep(2, 1, -1, lat);
    check("st1_cnt", cnt_s, 27);
    check("st1_first", ffv_s, 6'h15);
    check_results("st1", 1);

    mode = 2;
    run_sweep(2, 1, -1, lat);
    check("st0_cnt", cnt_s, 37);
    check("st0_first", ffv_s, 6'h00);
    check_results("st0", 1);

    mode = 3;
    for (int r = 0; r < 3; r++) begin
      mask = {$urandom, $urandom};
      run_sweep(2, 1, -1, lat);
      check_results("rnd", 1);
    end

    // Abort a stuck-at-1 run at vec 30, after failures have accumulated.
    mode = 1;
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    k = 0;
    while (stim_d != 6'd30 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    check("reach_vec30", stim_d, 30);
    check("pre_rst_fail", fl_d, 1);
    RN = 1'b0;
    #1;
    check("mid_rst_stim", stim_d, 0);
    check("mid_rst_busy", busy_d, 0);
    check("mid_rst_done", done_d, 0);
    check("mid_rst_fail", fl_d, 0);
    check("mid_rst_cnt", cnt_d, 0);
    check("mid_rst_ffv", ffv_d, 0);
    @(negedge CLK) RN = 1'b1;
    mode = 0;
    run_sweep(2, 1, -1, lat);
    check_results("after_rst", 1);

    sel = 1; mode = 2;
    run_sweep(2, 4, -1, lat);
    check("l4_lat", lat, 769);
    check("l4_cnt", cnt_s, 127);
    check_results("l4", 4);

    sel = 2; mode = 0;
    run_sweep(0, 1, 10, lat);
    check("s0_lat", lat, 65);
    check_results("s0", 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
